// File: rtl/push_cond_pkg.sv
// Shared types and 50 MHz default timing for the two-channel push-switch conditioner.
package push_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_DEB_CYCLES = 500000;    // 10 ms
    localparam int DEF_REP_DELAY  = 25000000;  // 500 ms
    localparam int DEF_REP_PERIOD = 5000000;   // 100 ms

endpackage

// File: rtl/push_channel.sv
// One button channel: 2-flop synchronizer, stability-count debounce and hold-to-repeat FSM.
// Exposes next-state level and raw pulse so the top can register them with chord lockout.
module push_channel
    import push_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REPEAT_EN  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    output logic level_nxt,
    output logic pulse_raw
);

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int TMR_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REP_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REP_PERIOD - 1);

    logic [1:0]       sync_q, sync_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    rep_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rise, fall;

    always_comb begin
        sync_d    = {sync_q[0], push};
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        if (sync_q[1] == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = ~level_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Release wins over a repeat that falls due on the same edge, so release never pulses.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pulse_raw = 1'b0;
        if (fall) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        pulse_raw = 1'b1;
                        timer_d   = '0;
                        if (REPEAT_EN != 0) state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (timer_q == DLY_LAST) begin
                        pulse_raw = 1'b1;
                        state_d   = REPEAT;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (timer_q == PER_LAST) begin
                        pulse_raw = 1'b1;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            state_q   <= IDLE;
            timer_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
        end
    end

    assign level_nxt = level_d;

endmodule

// File: rtl/push_conditioner.sv
// Two-channel push-switch conditioner: debounced levels, single-cycle press/repeat pulses,
// and chord lockout that blocks all pulses while both buttons are held.
module push_conditioner
    import push_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REPEAT_EN  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] PUSH,
    output logic [1:0] LEVEL,
    output logic [1:0] PULSE,
    output logic       CHORD
);

    logic [1:0] level_nxt, pulse_raw;
    logic [1:0] level_q, level_d;
    logic [1:0] pulse_q, pulse_d;
    logic       chord_q, chord_d;

    for (genvar i = 0; i < 2; i++) begin : g_chan
        push_channel #(
            .DEB_CYCLES(DEB_CYCLES),
            .REP_DELAY (REP_DELAY),
            .REP_PERIOD(REP_PERIOD),
            .REPEAT_EN (REPEAT_EN)
        ) u_chan (
            .clk      (CLK),
            .rst      (RST),
            .push     (PUSH[i]),
            .level_nxt(level_nxt[i]),
            .pulse_raw(pulse_raw[i])
        );
    end

    // Lockout uses next-state levels so a pulse landing on chord entry is already blocked.
    always_comb begin
        level_d = level_nxt;
        chord_d = &level_nxt;
        pulse_d = pulse_raw & ~{2{chord_d}};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q <= '0;
            pulse_q <= '0;
            chord_q <= 1'b0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
            chord_q <= chord_d;
        end
    end

    assign LEVEL = level_q;
    assign PULSE = pulse_q;
    assign CHORD = chord_q;

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner with DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8.
// Edge e counts posedges from the start of each scenario; outputs are compared 1 time unit after edge e.
module tb_push_conditioner;

    logic       CLK;
    logic       RST;
    logic [1:0] PUSH;
    logic [1:0] LEVEL, PULSE;
    logic       CHORD;
    logic [1:0] LEVEL_NR, PULSE_NR;
    logic       CHORD_NR;

    int n_checks;
    int n_fail;

    push_conditioner #(
        .DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(8), .REPEAT_EN(1)
    ) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .LEVEL(LEVEL), .PULSE(PULSE), .CHORD(CHORD)
    );

    push_conditioner #(
        .DEB_CYCLES(4), .REP_DELAY(20), .REP_PERIOD(8), .REPEAT_EN(0)
    ) dut_nr (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .LEVEL(LEVEL_NR), .PULSE(PULSE_NR), .CHORD(CHORD_NR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({LEVEL, PULSE, CHORD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_initial got %b want %b", {LEVEL, PULSE, CHORD}, 5'b0);
        end
        repeat (3) tick();
        RST  = 1'b0;
        PUSH = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {1'b0, (e >= 6), 1'b0, (e == 6), 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL reset_prepress e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
        end
        #2;
        RST  = 1'b1;
        PUSH = 2'b00;
        #1;
        n_checks++;
        if ({LEVEL, PULSE, CHORD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async got %b want %b", {LEVEL, PULSE, CHORD}, 5'b0);
        end
        tick();
        RST = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            n_checks++;
            if ({LEVEL, PULSE, CHORD, LEVEL_NR, PULSE_NR, CHORD_NR} !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_quiet e=%0d got %b want %b", e,
                         {LEVEL, PULSE, CHORD, LEVEL_NR, PULSE_NR, CHORD_NR}, 10'b0);
            end
        end
    endtask

    // PUSH[1] sampled high on edges 10..29: level up at 15, down at 35; the due
    // first repeat at 35 coincides with release and must not appear.
    task automatic test_clean_press();
        logic [4:0] exp;
        PUSH = 2'b00;
        for (int e = 1; e <= 45; e++) begin
            tick();
            exp = {(e >= 15 && e < 35), 1'b0, (e == 15), 1'b0, 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL clean_press e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
            if (e == 9)  PUSH[1] = 1'b1;
            if (e == 29) PUSH[1] = 1'b0;
        end
    endtask

    // Samples 1..20 bounce in pairs (1,1,0,0,...), steady 1 from edge 21 to 30, then 0.
    task automatic test_bounce();
        logic [4:0] exp;
        int         n;
        PUSH = 2'b01;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp = {1'b0, (e >= 26 && e < 36), 1'b0, (e == 26), 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL bounce e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
            n = e + 1;
            if (n <= 20)      PUSH[0] = (((n - 1) / 2) % 2 == 0);
            else if (n <= 30) PUSH[0] = 1'b1;
            else              PUSH[0] = 1'b0;
        end
    endtask

    // Press sampled at edge 1 -> p=6; repeats 26,34,42,50; release sampled at 53,
    // level falls at 58 where a repeat would otherwise have been due.
    task automatic test_auto_repeat();
        logic [4:0] exp, exp_nr;
        logic       lvl, rep;
        PUSH = 2'b10;
        for (int e = 1; e <= 70; e++) begin
            tick();
            lvl    = (e >= 6 && e < 58);
            rep    = (e == 6 || e == 26 || e == 34 || e == 42 || e == 50);
            exp    = {lvl, 1'b0, rep, 1'b0, 1'b0};
            exp_nr = {lvl, 1'b0, (e == 6), 1'b0, 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL auto_repeat e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
            n_checks++;
            if ({LEVEL_NR, PULSE_NR, CHORD_NR} !== exp_nr) begin
                n_fail++;
                $display("FAIL no_repeat e=%0d got %b want %b", e, {LEVEL_NR, PULSE_NR, CHORD_NR}, exp_nr);
            end
            if (e == 52) PUSH = 2'b00;
        end
    endtask

    // PUSH[1] from edge 1 (p=6); PUSH[0] sampled high edges 10..35 -> chord 15..40.
    // Press of ch0 at 15 and ch1 repeats at 26,34 are blocked; 42 and 50 pass.
    task automatic test_chord();
        logic [4:0] exp;
        logic       ch;
        PUSH = 2'b10;
        for (int e = 1; e <= 65; e++) begin
            tick();
            ch  = (e >= 15 && e < 41);
            exp = {(e >= 6 && e < 58), ch, (e == 6 || e == 42 || e == 50), 1'b0, ch};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL chord e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
            if (e == 9)  PUSH[0] = 1'b1;
            if (e == 35) PUSH[0] = 1'b0;
            if (e == 52) PUSH[1] = 1'b0;
        end
    endtask

    // Reset while in REPEAT; first post-reset sample at edge 32 -> fresh press at 37.
    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        PUSH = 2'b10;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp = {(e >= 6), 1'b0, (e == 6 || e == 26), 1'b0, 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL hold_prereset e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({LEVEL, PULSE, CHORD} !== 5'b0) begin
            n_fail++;
            $display("FAIL hold_reset_async got %b want %b", {LEVEL, PULSE, CHORD}, 5'b0);
        end
        tick();
        RST = 1'b0;
        for (int e = 32; e <= 55; e++) begin
            tick();
            exp = {(e >= 37 && e < 51), 1'b0, (e == 37), 1'b0, 1'b0};
            n_checks++;
            if ({LEVEL, PULSE, CHORD} !== exp) begin
                n_fail++;
                $display("FAIL hold_postreset e=%0d got %b want %b", e, {LEVEL, PULSE, CHORD}, exp);
            end
            if (e == 45) PUSH = 2'b00;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b0;
        PUSH     = 2'b00;
        #1;
        test_reset();
        repeat (5) tick();
        test_clean_press();
        repeat (5) tick();
        test_bounce();
        repeat (5) tick();
        test_auto_repeat();
        repeat (5) tick();
        test_chord();
        repeat (5) tick();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
